// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings for the multicycle control FSM
//
// Holds the FSM state codes (also visible on state_out), the ALU operation
// codes, the MIPS-subset opcode/funct values, the alu_src_b and pc_source
// selector encodings, and the exception cause codes.
package control_pkg;

    typedef enum logic [6:0] {
        S_RESET     = 7'd0,
        S_FETCH     = 7'd1,
        S_DECODE    = 7'd2,
        S_MEM_ADDR  = 7'd3,
        S_MEM_READ  = 7'd4,
        S_MEM_WB    = 7'd5,
        S_MEM_WRITE = 7'd6,
        S_R_EXEC    = 7'd7,
        S_R_WB      = 7'd8,
        S_ADDI_EXEC = 7'd9,
        S_ADDI_WB   = 7'd10,
        S_BRANCH    = 7'd11,
        S_JUMP      = 7'd12,
        S_EXC       = 7'd13
    } state_e;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_EXC    = 2'd3;

    localparam logic CAUSE_INVALID  = 1'b0;
    localparam logic CAUSE_OVERFLOW = 1'b1;

    // ALU code for an R-type funct; ALU_NONE marks an unsupported funct.
    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - clearable up-counter timing multi-cycle FSM states
//
// Ports: clock, reset (sync, active-high), load (clear to 0), count
// (increment), limit (cycles the current state lasts), done (this is the
// last cycle of the current state).
module wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             count,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] value;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            value <= '0;
        end else if (count) begin
            value <= value + WIDTH'(1);
        end
    end

    assign done = (value == limit - WIDTH'(1));

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM
//
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type,
// addi, beq, bne and j, with MEM_LATENCY-cycle memory accesses, a
// RESET_CYCLES hold after reset and precise exceptions.
// Ports: clock, reset (sync, active-high); opcode/funct from the IR;
// overflow/zero from the ALU; datapath enables pc_write, ir_write, mem_wr,
// iord, reg_write, reg_dst, mem_to_reg, epc_write; selects alu_src_a,
// alu_src_b, alu_op, pc_source; cause (valid with epc_write); state_out.
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int RESET_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       epc_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       cause,
    output logic [6:0] state_out
);

    localparam int MAX_WAIT = (MEM_LATENCY > RESET_CYCLES) ? MEM_LATENCY : RESET_CYCLES;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    state_e        state;
    state_e        next_state;
    logic          cause_q;
    logic          next_cause;
    logic          counted;
    logic          advance;
    logic          wait_done;
    logic [CW-1:0] wait_limit;
    logic [2:0]    r_alu_op;
    logic          r_arith;

    assign r_alu_op = funct_alu_op(funct);
    assign r_arith  = (funct == FN_ADD) || (funct == FN_SUB);

    // Only these states last more than one cycle; every other state leaves
    // after a single cycle, so the counter is cleared on each state change.
    assign counted    = state inside {S_RESET, S_FETCH, S_MEM_READ, S_MEM_WRITE};
    assign wait_limit = (state == S_RESET) ? CW'(RESET_CYCLES) : CW'(MEM_LATENCY);
    assign advance    = counted ? wait_done : 1'b1;

    wait_counter #(
        .WIDTH(CW)
    ) u_wait (
        .clock(clock),
        .reset(reset),
        .load (advance),
        .count(counted),
        .limit(wait_limit),
        .done (wait_done)
    );

    // Destination when the current state is left; unsupported funct codes
    // are rejected already in DECODE so R_EXEC always has a valid ALU op.
    always_comb begin
        next_state = state;
        next_cause = cause_q;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (r_alu_op != ALU_NONE) begin
                            next_state = S_R_EXEC;
                        end else begin
                            next_state = S_EXC;
                            next_cause = CAUSE_INVALID;
                        end
                    end
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_ADDI:        next_state = S_ADDI_EXEC;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    default: begin
                        next_state = S_EXC;
                        next_cause = CAUSE_INVALID;
                    end
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: next_state = S_MEM_WB;
            S_R_EXEC: begin
                if (r_arith && overflow) begin
                    next_state = S_EXC;
                    next_cause = CAUSE_OVERFLOW;
                end else begin
                    next_state = S_R_WB;
                end
            end
            S_ADDI_EXEC: begin
                if (overflow) begin
                    next_state = S_EXC;
                    next_cause = CAUSE_OVERFLOW;
                end else begin
                    next_state = S_ADDI_WB;
                end
            end
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_RESET;
            cause_q <= CAUSE_INVALID;
        end else if (advance) begin
            state   <= next_state;
            cause_q <= next_cause;
        end
    end

    // Moore decode of the current state; BRANCH additionally looks at zero.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        epc_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_NONE;
        pc_source  = PCSRC_ALU;
        cause      = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = wait_done;
                pc_write  = wait_done;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_READ: iord = 1'b1;
            S_MEM_WRITE: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BEQ) ? zero : !zero;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            S_EXC: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_source = PCSRC_EXC;
                cause     = cause_q;
            end
            default: ;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
    import control_pkg::*;

    localparam int L  = 3;
    localparam int RC = 3;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [5:0] opcode   = 6'h00;
    logic [5:0] funct    = 6'h00;
    logic       overflow = 1'b0;
    logic       zero     = 1'b0;
    logic       pc_write, ir_write, mem_wr, iord, reg_write, reg_dst;
    logic       mem_to_reg, epc_write, alu_src_a, cause;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [6:0] state_out;

    always #5 clock = ~clock;

    multicycle_control #(
        .MEM_LATENCY (L),
        .RESET_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
        .mem_wr(mem_wr), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .epc_write(epc_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .cause(cause), .state_out(state_out)
    );

    // One planned clock cycle: inputs to apply and the outputs they must give.
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        logic        zr;
        logic [23:0] exp;
        int          id;
    } cyc_t;

    cyc_t plan[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   instr_id = 0;

    // Output vector that a given phase must show, straight from the per-state table.
    function automatic logic [23:0] expect_outs(input state_e st, input bit last,
                                                input logic [5:0] op, input logic [5:0] fn,
                                                input logic zr, input logic cs);
        logic pcw = 0, irw = 0, mw = 0, io = 0, rw = 0, rd = 0, m2r = 0, epc = 0, sa = 0, c = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] aop = 0;
        case (st)
            S_FETCH:     begin sb = 1; aop = 1; pcw = last; irw = last; end
            S_DECODE:    begin sb = 3; aop = 1; end
            S_MEM_ADDR,
            S_ADDI_EXEC: begin sa = 1; sb = 2; aop = 1; end
            S_MEM_READ:  io = 1;
            S_MEM_WRITE: begin io = 1; mw = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_R_EXEC: begin
                sa  = 1;
                aop = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 :
                      (fn == 6'h25) ? 3'd4 : 3'd5;
            end
            S_R_WB:      begin rw = 1; rd = 1; end
            S_ADDI_WB:   rw = 1;
            S_BRANCH:    begin sa = 1; aop = 2; ps = 1; pcw = (op == 6'h04) ? zr : !zr; end
            S_JUMP:      begin ps = 2; pcw = 1; end
            S_EXC:       begin epc = 1; pcw = 1; ps = 3; c = cs; end
            default: ;
        endcase
        return {7'(st), pcw, irw, mw, io, rw, rd, m2r, epc, sa, sb, aop, ps, c};
    endfunction

    task automatic pin(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // n_high cycles with reset held, then the RC-cycle hold after release.
    task automatic push_reset(input int n_high);
        cyc_t c;
        for (int i = 0; i < n_high + RC; i++) begin
            c.rst = (i < n_high); c.op = 0; c.fn = 0; c.ovf = 0; c.zr = 0; c.id = -1;
            c.exp = expect_outs(S_RESET, 0, 0, 0, 0, 0);
            plan.push_back(c);
        end
    endtask

    // Expands one instruction into its phase sequence; abort_at asserts reset
    // on that cycle of the instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                             input logic zr, input int abort_at, output int len);
        state_e seq[$];
        logic   cs = 1'b0;
        bit     rvalid;
        bit     arith;
        cyc_t   c;
        rvalid = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
        arith  = (fn == 6'h20) || (fn == 6'h22);
        for (int i = 0; i < L; i++) seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (op)
            6'h00: begin
                if (!rvalid) seq.push_back(S_EXC);
                else begin
                    seq.push_back(S_R_EXEC);
                    if (arith && ovf) begin seq.push_back(S_EXC); cs = 1; end
                    else seq.push_back(S_R_WB);
                end
            end
            6'h23: begin
                seq.push_back(S_MEM_ADDR);
                for (int i = 0; i < L; i++) seq.push_back(S_MEM_READ);
                seq.push_back(S_MEM_WB);
            end
            6'h2B: begin
                seq.push_back(S_MEM_ADDR);
                for (int i = 0; i < L; i++) seq.push_back(S_MEM_WRITE);
            end
            6'h08: begin
                seq.push_back(S_ADDI_EXEC);
                if (ovf) begin seq.push_back(S_EXC); cs = 1; end
                else seq.push_back(S_ADDI_WB);
            end
            6'h04, 6'h05: seq.push_back(S_BRANCH);
            6'h02:        seq.push_back(S_JUMP);
            default:      seq.push_back(S_EXC);
        endcase
        len = 0;
        for (int i = 0; i < seq.size(); i++) begin
            c.rst = (i == abort_at); c.op = op; c.fn = fn; c.ovf = ovf; c.zr = zr; c.id = instr_id;
            c.exp = expect_outs(seq[i], (i == L - 1), op, fn, zr, cs);
            plan.push_back(c);
            len++;
            if (i == abort_at) begin
                push_reset(0);
                break;
            end
        end
        instr_id++;
    endtask

    initial begin
        int len;
        int rw_seen  = 0;
        int epc_seen = 0;
        int mw_seen  = 0;
        int irw_seen = 0;
        logic [23:0] got;

        pin("vec_beq_taken", int'(expect_outs(S_BRANCH, 0, 6'h04, 6'h00, 1'b1, 1'b0)), 24'h170112);
        pin("vec_exc_ovf", int'(expect_outs(S_EXC, 0, 6'h00, 6'h20, 1'b0, 1'b1)), 24'h1B0207);

        push_reset(2);
        run_instr(6'h23, 6'h00, 0, 0, -1, len); pin("cpi_lw", len, 9);
        run_instr(6'h00, 6'h20, 0, 0, -1, len); pin("cpi_add", len, 6);
        run_instr(6'h00, 6'h20, 1, 0, -1, len); pin("cpi_add_ovf", len, 6);
        run_instr(6'h00, 6'h22, 1, 0, -1, len);
        run_instr(6'h00, 6'h24, 1, 0, -1, len);
        run_instr(6'h00, 6'h25, 0, 1, -1, len);
        run_instr(6'h00, 6'h2A, 0, 0, -1, len);
        run_instr(6'h08, 6'h00, 1, 0, -1, len); pin("cpi_addi_ovf", len, 6);
        run_instr(6'h00, 6'h07, 0, 0, -1, len); pin("cpi_bad_funct", len, 5);
        run_instr(6'h3F, 6'h00, 0, 0, -1, len); pin("cpi_bad_op", len, 5);
        run_instr(6'h08, 6'h11, 0, 0, -1, len);
        run_instr(6'h04, 6'h00, 0, 1, -1, len); pin("cpi_beq", len, 5);
        run_instr(6'h04, 6'h00, 0, 0, -1, len);
        run_instr(6'h05, 6'h00, 0, 1, -1, len);
        run_instr(6'h05, 6'h00, 0, 0, -1, len);
        run_instr(6'h02, 6'h00, 0, 0, -1, len);
        run_instr(6'h2B, 6'h00, 0, 0, -1, len); pin("cpi_sw", len, 8);
        run_instr(6'h2B, 6'h00, 0, 0, 6, len);
        run_instr(6'h23, 6'h00, 1, 0, -1, len);

        foreach (plan[k]) begin
            @(posedge clock);
            #1;
            reset    = plan[k].rst;
            opcode   = plan[k].op;
            funct    = plan[k].fn;
            overflow = plan[k].ovf;
            zero     = plan[k].zr;
            @(negedge clock);
            got = {state_out, pc_write, ir_write, mem_wr, iord, reg_write, reg_dst, mem_to_reg,
                   epc_write, alu_src_a, alu_src_b, alu_op, pc_source, cause};
            n_checks++;
            if (got !== plan[k].exp) begin
                n_errors++;
                $display("FAIL cycle %0d instr %0d: outputs got %h expected %h (state got %0d expected %0d)",
                         k, plan[k].id, got, plan[k].exp, got[23:17], plan[k].exp[23:17]);
            end
            rw_seen  += int'(reg_write);
            epc_seen += int'(epc_write);
            mw_seen  += int'(mem_wr);
            irw_seen += int'(ir_write);
        end

        pin("reg_write_cycles", rw_seen, 7);
        pin("epc_write_cycles", epc_seen, 5);
        pin("mem_wr_cycles", mw_seen, 5);
        pin("ir_write_cycles", irw_seen, 19);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control FSM for the MIPS-subset datapath. It decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback. It also handles a variable-latency memory, a configurable reset hold and precise exceptions (invalid opcode, arithmetic overflow). It drives every datapath mux/write-enable and sits between the instruction register and the datapath.

## Interface
- `MEM_LATENCY`, default 1: cycles each memory access occupies (≥1).
- `RESET_CYCLES`, default 1: cycles spent in RESET after `reset` deasserts (≥1).
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from end of FETCH until next FETCH.
- `funct` in 6: IR[5:0].
- `overflow` in 1: ALU signed overflow, same cycle.
- `zero` in 1: ALU zero flag, same cycle.
- `pc_write`, `ir_write`, `mem_wr`, `iord`, `reg_write`, `reg_dst`, `mem_to_reg`, `epc_write` out 1: datapath enables/selects.
- `alu_src_a` out 1: 0=PC, 1=A.
- `alu_src_b` out 2: 0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- `alu_op` out 3: package ALU code.
- `pc_source` out 2: 0=ALU result, 1=ALUOut, 2=jump target, 3=exception vector.
- `cause` out 1: 0=invalid opcode, 1=overflow; valid when `epc_write`=1.
- `state_out` out 7: current state code, debug.

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, EXC.
- Outputs are Moore: a function of state and wait counter. Exception: `pc_write` in BRANCH also uses `zero`. Any signal not listed for a state is 0.
- RESET: all outputs 0. Hold RESET_CYCLES cycles, then go to FETCH.
- FETCH (wait counter, MEM_LATENCY cycles): `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_source`=0. On the last cycle only, `ir_write`=1 and `pc_write`=1. Then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00 → R_EXEC
  - 0x23/0x2B → MEM_ADDR
  - 0x08 → ADDI_EXEC
  - 0x04/0x05 → BRANCH
  - 0x02 → JUMP
  - else → EXC with `cause`=0
- R-type funct codes: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other funct → EXC with `cause`=0.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op` from funct. If funct is ADD/SUB and `overflow`=1 → EXC with `cause`=1; otherwise → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=2, ADD. `overflow`=1 → EXC with `cause`=1; otherwise → ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0 → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, ADD. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ / MEM_WRITE: `iord`=1 for MEM_LATENCY cycles. `mem_wr`=1 on every MEM_WRITE cycle. MEM_READ → MEM_WB; MEM_WRITE → FETCH.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_source`=1. `pc_write` = (beq & `zero`) | (bne & !`zero`). → FETCH.
- JUMP: `pc_source`=2, `pc_write`=1 → FETCH.
- EXC: `epc_write`=1, `pc_write`=1, `pc_source`=3, `cause` held from the transition into EXC (registered). → FETCH.
- No register write or memory write ever occurs for a faulting instruction.

## Timing
- `reset` high on any edge → next state RESET, wait counter 0, `cause` 0. Reset mid-access aborts it; `mem_wr` drops the following cycle.
- CPI (L = MEM_LATENCY):
  - R-type/addi: L+3
  - lw: 2L+3
  - sw: 2L+2
  - beq/bne/j: L+2
  - exception: one cycle after the faulting state
- Wait counter: width $clog2(max(MEM_LATENCY,RESET_CYCLES)+1). Clear on every state change. When MEM_LATENCY=1 there are no wait cycles.
- `overflow` and `zero` are sampled in the same cycle the ALU operation is issued.

## Structure
- Package `control_pkg`: state enum (7-bit), ALU op codes (ADD=1, SUB=2, AND=3, OR=4, SLT=5), opcode/funct constants, `alu_src_b`/`pc_source` encodings.
- Sub-module `wait_counter` (load, count, done) shared by RESET, FETCH, MEM_READ and MEM_WRITE.

## Test plan
- Reset with RESET_CYCLES=3: `reset` 1 for 2 cycles, then 0 → 3 cycles in RESET with all outputs 0, then FETCH.
- MEM_LATENCY=3, opcode 0x23 → `ir_write` only on 3rd FETCH cycle, `iord`=1 for 3 MEM_READ cycles, `reg_write`+`mem_to_reg` in MEM_WB; 9 cycles total.
- R-type funct 0x20 with `overflow`=1 → EXC next cycle, `cause`=1, `epc_write`=1, `pc_source`=3, never `reg_write`.
- Opcode 0x3F → DECODE→EXC, `cause`=0; funct 0x07 with opcode 0 → EXC, `cause`=0.
- beq with `zero`=1 → `pc_write`=1, `pc_source`=1; bne with `zero`=1 → `pc_write`=0.
- sw, reset asserted during 2nd MEM_WRITE cycle (L=3) → `mem_wr`=0 next cycle, state RESET.
